// File: rtl/alu.sv
// Single-cycle registered RV32 integer ALU: ADD/SUB, shifts, compares, logic ops.
// Optional registered signed-overflow flag when ALU_OVERFLOW_FLAG_EN is defined.
module alu (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic [31:0] operand1,
    input  logic [31:0] operand2,
    input  logic [2:0]  ALUControl,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    output logic [31:0] result,
    output logic        zero,
`ifdef ALU_OVERFLOW_FLAG_EN
    output logic        overflow,
`endif
    output logic        valid_out
);

    typedef enum logic [2:0] {
        OP_ADDSUB = 3'b000,
        OP_SLL    = 3'b001,
        OP_SLT    = 3'b010,
        OP_SLTU   = 3'b011,
        OP_XOR    = 3'b100,
        OP_SRX    = 3'b101,
        OP_OR     = 3'b110,
        OP_AND    = 3'b111
    } alu_op_e;

    alu_op_e     op;
    logic        alt;
    logic        do_sub;
    logic [31:0] b_eff;
    logic [32:0] sum;
    logic        lt_u;
    logic        lt_s;
    logic [4:0]  shamt;
    logic [31:0] sll_res;
    logic [31:0] srx_res;
    logic [31:0] alu_res;
    logic        add_ovf;

    // funct3 and the non-decoded funct7 bits are carried for completeness only.
    logic unused_inputs;
    assign unused_inputs = ^{funct3, funct7[6], funct7[4:0]};

    assign op    = alu_op_e'(ALUControl);
    assign alt   = funct7[5];
    assign shamt = operand2[4:0];

    // One shared adder: compares always subtract, so their flags come from the borrow/sign.
    always_comb begin
        do_sub = (op == OP_ADDSUB) ? alt : 1'b1;
        b_eff  = do_sub ? ~operand2 : operand2;
        sum    = {1'b0, operand1} + {1'b0, b_eff} + {32'd0, do_sub};
        lt_u   = ~sum[32];
        lt_s   = (operand1[31] ^ operand2[31]) ? operand1[31] : sum[31];
        add_ovf = (operand1[31] == b_eff[31]) && (sum[31] != operand1[31]);
    end

    always_comb begin
        sll_res = operand1 << shamt;
        if (alt) begin
            srx_res = $unsigned($signed(operand1) >>> shamt);
        end else begin
            srx_res = operand1 >> shamt;
        end
    end

    always_comb begin
        alu_res = 32'd0;
        unique case (op)
            OP_ADDSUB: alu_res = sum[31:0];
            OP_SLL:    alu_res = sll_res;
            OP_SLT:    alu_res = {31'd0, lt_s};
            OP_SLTU:   alu_res = {31'd0, lt_u};
            OP_XOR:    alu_res = operand1 ^ operand2;
            OP_SRX:    alu_res = srx_res;
            OP_OR:     alu_res = operand1 | operand2;
            OP_AND:    alu_res = operand1 & operand2;
            default:   alu_res = 32'd0;
        endcase
    end

    logic [31:0] result_d, result_q;
    logic        zero_d, zero_q;
    logic        valid_d, valid_q;

    // Outputs hold when no operation is issued; zero tracks the registered result.
    always_comb begin
        result_d = result_q;
        zero_d   = zero_q;
        valid_d  = valid_in;
        if (valid_in) begin
            result_d = alu_res;
            zero_d   = (alu_res == 32'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= 32'd0;
            zero_q   <= 1'b1;
            valid_q  <= 1'b0;
        end else begin
            result_q <= result_d;
            zero_q   <= zero_d;
            valid_q  <= valid_d;
        end
    end

    assign result    = result_q;
    assign zero      = zero_q;
    assign valid_out = valid_q;

`ifdef ALU_OVERFLOW_FLAG_EN
    logic overflow_d, overflow_q;

    always_comb begin
        overflow_d = overflow_q;
        if (valid_in) begin
            overflow_d = (op == OP_ADDSUB) && add_ovf;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign overflow = overflow_q;
`else
    logic unused_ovf;
    assign unused_ovf = add_ovf;
`endif

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vectors, timing/reset scenarios and
// randomized operations against an arithmetic reference model.
module tb_alu;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic [31:0] operand1, operand2;
    logic [2:0]  ALUControl, funct3;
    logic [6:0]  funct7;
    logic [31:0] result;
    logic        zero, valid_out;
    logic        ovf_obs;
`ifdef ALU_OVERFLOW_FLAG_EN
    logic        overflow;
    assign ovf_obs = overflow;
`else
    assign ovf_obs = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu dut (
        .clk(clk),
        .rst(rst),
        .valid_in(valid_in),
        .operand1(operand1),
        .operand2(operand2),
        .ALUControl(ALUControl),
        .funct3(funct3),
        .funct7(funct7),
        .result(result),
        .zero(zero),
`ifdef ALU_OVERFLOW_FLAG_EN
        .overflow(overflow),
`endif
        .valid_out(valid_out)
    );

    // Reference model: plain integer arithmetic on 64-bit values.
    function automatic void model(input logic [2:0] c, input logic [6:0] f,
                                  input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic ov);
        longint sa, sb, ua, ub, t;
        int sh;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        sh = int'(b % 32);
        ov = 1'b0;
        r  = 32'd0;
        case (c)
            3'd0: begin
                t  = f[5] ? sa - sb : sa + sb;
                ov = (t > 64'sd2147483647) || (t < -64'sd2147483648);
                r  = t[31:0];
            end
            3'd1: begin t = ua * (longint'(1) << sh); r = t[31:0]; end
            3'd2: r = (sa < sb) ? 32'd1 : 32'd0;
            3'd3: r = (ua < ub) ? 32'd1 : 32'd0;
            3'd4: r = a ^ b;
            3'd5: begin
                if (f[5]) t = (sa >= 0) ? sa / (longint'(1) << sh)
                                        : -((-sa + (longint'(1) << sh) - 1) / (longint'(1) << sh));
                else      t = ua / (longint'(1) << sh);
                r = t[31:0];
            end
            3'd6: r = a | b;
            default: r = a & b;
        endcase
    endfunction

    // Drive one operation and step past the capturing edge.
    task automatic issue(input logic [2:0] c, input logic [6:0] f,
                         input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        valid_in   = 1'b1;
        ALUControl = c;
        funct7     = f;
        funct3     = 3'($urandom);
        operand1   = a;
        operand2   = b;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; valid_in = 1'b1;
        ALUControl = 3'd0; funct7 = 7'd0; operand1 = 32'd5; operand2 = 32'd3;
        @(posedge clk); #1;
        total++;
        if (result !== 32'd0 || zero !== 1'b1 || valid_out !== 1'b0 || ovf_obs !== 1'b0) begin
            bad++;
            $display("FAIL reset: got r=%h z=%b v=%b o=%b want r=0 z=1 v=0 o=0", result, zero, valid_out, ovf_obs);
        end
        @(negedge clk);
        rst = 1'b0; valid_in = 1'b0;
    endtask

    typedef struct {
        logic [2:0]  c;
        logic [6:0]  f;
        logic [31:0] a, b, r;
        logic        z, o;
        string       name;
    } vec_t;

    task automatic test_directed();
        vec_t v[$];
        v.push_back('{3'd0, 7'h00, 32'h5,        32'h3,        32'h8,        1'b0, 1'b0, "add_5_3"});
        v.push_back('{3'd0, 7'h00, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b1, 1'b0, "add_wrap"});
        v.push_back('{3'd0, 7'h20, 32'hA,        32'h3,        32'h7,        1'b0, 1'b0, "sub_a_3"});
        v.push_back('{3'd0, 7'h20, 32'h3,        32'hA,        32'hFFFFFFF9, 1'b0, 1'b0, "sub_3_a"});
        v.push_back('{3'd0, 7'h20, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b1, "sub_ovf"});
        v.push_back('{3'd1, 7'h00, 32'h1,        32'h4,        32'h10,       1'b0, 1'b0, "sll_1_4"});
        v.push_back('{3'd1, 7'h20, 32'hF0000000, 32'h1,        32'hE0000000, 1'b0, 1'b0, "sll_f0"});
        v.push_back('{3'd5, 7'h00, 32'h80000000, 32'h4,        32'h08000000, 1'b0, 1'b0, "srl"});
        v.push_back('{3'd5, 7'h20, 32'h80000000, 32'h4,        32'hF8000000, 1'b0, 1'b0, "sra_neg"});
        v.push_back('{3'd5, 7'h20, 32'h40000000, 32'h4,        32'h04000000, 1'b0, 1'b0, "sra_pos"});
        v.push_back('{3'd2, 7'h00, 32'hFFFFFFFE, 32'h1,        32'h1,        1'b0, 1'b0, "slt_neg"});
        v.push_back('{3'd3, 7'h00, 32'hFFFFFFFE, 32'h1,        32'h0,        1'b1, 1'b0, "sltu"});
        v.push_back('{3'd2, 7'h00, 32'h5,        32'hA,        32'h1,        1'b0, 1'b0, "slt_5_a"});
        v.push_back('{3'd2, 7'h20, 32'hA,        32'h5,        32'h0,        1'b1, 1'b0, "slt_a_5"});
        v.push_back('{3'd4, 7'h00, 32'h55555555, 32'hAAAAAAAA, 32'hFFFFFFFF, 1'b0, 1'b0, "xor_ff"});
        v.push_back('{3'd4, 7'h7F, 32'h12345678, 32'h12345678, 32'h0,        1'b1, 1'b0, "xor_self"});
        v.push_back('{3'd6, 7'h00, 32'h00001111, 32'h11110000, 32'h11111111, 1'b0, 1'b0, "or"});
        v.push_back('{3'd7, 7'h20, 32'h00001111, 32'h11111111, 32'h00001111, 1'b0, 1'b0, "and"});
        v.push_back('{3'd1, 7'h00, 32'hDEADBEEF, 32'hFFFFFFE0, 32'hDEADBEEF, 1'b0, 1'b0, "sll_sh0"});
        v.push_back('{3'd5, 7'h00, 32'h8000BEEF, 32'h00000020, 32'h8000BEEF, 1'b0, 1'b0, "srl_sh0"});
        v.push_back('{3'd5, 7'h20, 32'h8000BEEF, 32'h0,        32'h8000BEEF, 1'b0, 1'b0, "sra_sh0"});
        v.push_back('{3'd0, 7'h00, 32'h7FFFFFFF, 32'h1,        32'h80000000, 1'b0, 1'b1, "add_ovf"});
        foreach (v[i]) begin
            issue(v[i].c, v[i].f, v[i].a, v[i].b);
            total++;
            if (result !== v[i].r || zero !== v[i].z || valid_out !== 1'b1) begin
                bad++;
                $display("FAIL %s: got r=%h z=%b v=%b want r=%h z=%b v=1",
                         v[i].name, result, zero, valid_out, v[i].r, v[i].z);
            end
`ifdef ALU_OVERFLOW_FLAG_EN
            total++;
            if (overflow !== v[i].o) begin
                bad++;
                $display("FAIL %s_ovf: got %b want %b", v[i].name, overflow, v[i].o);
            end
`endif
        end
    endtask

    task automatic test_timing();
        logic [31:0] hold_r;
        // Gap after a pulse: outputs hold, valid_out drops.
        issue(3'd0, 7'h00, 32'h100, 32'h23);
        hold_r = 32'h123;
        for (int g = 0; g < 3; g++) begin
            @(negedge clk);
            valid_in = 1'b0;
            operand1 = $urandom; operand2 = $urandom; ALUControl = 3'($urandom);
            @(posedge clk); #1;
            total++;
            if (result !== hold_r || zero !== 1'b0 || valid_out !== 1'b0) begin
                bad++;
                $display("FAIL hold_%0d: got r=%h z=%b v=%b want r=%h z=0 v=0", g, result, zero, valid_out, hold_r);
            end
        end
        // Reset mid-stream wins over a coincident valid_in.
        issue(3'd4, 7'h00, 32'hF0F0F0F0, 32'h0F0F0F0F);
        @(negedge clk);
        rst = 1'b1; valid_in = 1'b1; operand1 = 32'h1; operand2 = 32'h1; ALUControl = 3'd0;
        @(posedge clk); #1;
        total++;
        if (result !== 32'd0 || zero !== 1'b1 || valid_out !== 1'b0 || ovf_obs !== 1'b0) begin
            bad++;
            $display("FAIL midreset: got r=%h z=%b v=%b want r=0 z=1 v=0", result, zero, valid_out);
        end
        @(negedge clk);
        rst = 1'b0; valid_in = 1'b0;
        @(posedge clk); #1;
        total++;
        if (valid_out !== 1'b0 || result !== 32'd0) begin
            bad++;
            $display("FAIL post_reset_idle: got r=%h v=%b want r=0 v=0", result, valid_out);
        end
        issue(3'd6, 7'h00, 32'hA0, 32'h0B);
        total++;
        if (result !== 32'hAB || valid_out !== 1'b1 || zero !== 1'b0) begin
            bad++;
            $display("FAIL first_after_reset: got r=%h v=%b want r=000000ab v=1", result, valid_out);
        end
    endtask

    // Random traffic with gaps and occasional resets; latency is exactly one edge.
    task automatic test_random();
        logic [31:0] exp_r, r;
        logic        exp_z, exp_o, o, v, rs;
        exp_r = result; exp_z = zero; exp_o = ovf_obs;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            v  = ($urandom_range(0, 9) < 7);
            rs = ($urandom_range(0, 39) == 0);
            rst = rs; valid_in = v;
            ALUControl = 3'($urandom);
            funct7 = 7'($urandom);
            funct3 = 3'($urandom);
            case ($urandom_range(0, 3))
                0: begin operand1 = $urandom; operand2 = $urandom_range(0, 40); end
                1: begin operand1 = 32'h7FFFFFFF ^ 32'($urandom_range(0, 3)); operand2 = 32'h80000000 | $urandom_range(0, 3); end
                2: begin operand1 = $urandom; operand2 = operand1; end
                default: begin operand1 = $urandom; operand2 = $urandom; end
            endcase
            model(ALUControl, funct7, operand1, operand2, r, o);
            if (rs) begin
                exp_r = 32'd0; exp_z = 1'b1; exp_o = 1'b0;
            end else if (v) begin
                exp_r = r; exp_z = (r == 32'd0); exp_o = o;
            end
            @(posedge clk); #1;
            total++;
            if (result !== exp_r || zero !== exp_z || valid_out !== (v && !rs)) begin
                bad++;
                $display("FAIL rand_%0d: got r=%h z=%b v=%b want r=%h z=%b v=%b",
                         n, result, zero, valid_out, exp_r, exp_z, v && !rs);
            end
`ifdef ALU_OVERFLOW_FLAG_EN
            total++;
            if (overflow !== exp_o) begin
                bad++;
                $display("FAIL rand_ovf_%0d: got %b want %b", n, overflow, exp_o);
            end
`endif
        end
        @(negedge clk);
        rst = 1'b0; valid_in = 1'b0;
    endtask

    initial begin
        rst = 1'b1; valid_in = 1'b0;
        operand1 = '0; operand2 = '0; ALUControl = '0; funct3 = '0; funct7 = '0;
        repeat (2) @(posedge clk);
        test_reset();
        test_directed();
        test_timing();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
